// File: rtl/hy4_pkg.sv
// Shared types and helpers for the hy4 digit-serial signed MAC.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package hy4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Radix-4 Booth digit, range -2..+2
    typedef logic signed [2:0] digit_t;

    // Recode the bit triple {x[2i+1], x[2i], x[2i-1]} into a Booth digit
    function automatic digit_t booth_digit(input logic [2:0] b);
        case (b)
            3'b001, 3'b010: return 3'b001;   // +1
            3'b011:         return 3'b010;   // +2
            3'b100:         return 3'b110;   // -2
            3'b101, 3'b110: return 3'b111;   // -1
            default:        return 3'b000;   // 000 / 111 -> 0
        endcase
    endfunction

    function automatic int calc_ndig(input int dw);
        return dw / 2;
    endfunction

    function automatic int calc_aw(input int dw, input int cw, input int guard);
        return dw + cw + guard;
    endfunction

    // Digit counter width, never less than one bit
    function automatic int calc_cntw(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/hy4_booth_pp.sv
// Booth partial product: digit * coef << 2*shift, sign-extended to AW bits.
// Latency: combinational.
// Backpressure: none; negation is ~pp here plus neg injected as a +1 by the caller.
module hy4_booth_pp
    import hy4_pkg::*;
#(
    parameter int CW = 8,
    parameter int AW = 26,
    parameter int SW = 3
) (
    input  digit_t          digit,
    input  logic [CW-1:0]   coef,
    input  logic [SW-1:0]   shift,
    output logic [AW-1:0]   pp,
    output logic            neg
);

    logic [AW-1:0] c_ext;
    logic [AW-1:0] mag;
    logic [AW-1:0] shifted;

    // Select |digit| * coef, shift into digit position, one's-complement when negative
    always_comb begin
        c_ext   = {{(AW-CW){coef[CW-1]}}, coef};
        mag     = '0;
        neg     = digit[2];
        case (digit)
            3'b001, 3'b111: mag = c_ext;
            3'b010, 3'b110: mag = c_ext << 1;
            default:        mag = '0;
        endcase
        shifted = mag << {shift, 1'b0};
        pp      = neg ? ~shifted : shifted;
    end

endmodule

// File: rtl/hy4_serial_mac.sv
// Digit-serial signed MAC: radix-4 Booth, carry-save accumulate, one resolve cycle.
// Latency: out_valid NDIG+1 cycles after acceptance; one result per NDIG+2 cycles sustained.
// Backpressure: result held in DONE until out_ready; new operands accepted on that same edge.
// Optional: define HY4_SAT_EN to saturate out_y to the signed OW range (accumulator still wraps).
module hy4_serial_mac
    import hy4_pkg::*;
#(
    parameter int DW    = 14,
    parameter int CW    = 8,
    parameter int GUARD = 4,
    parameter int OW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_x,
    input  logic [CW-1:0]   in_c,
    input  logic            in_acc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   out_y,
    output logic            busy
);

    localparam int NDIG = calc_ndig(DW);
    localparam int AW   = calc_aw(DW, CW, GUARD);
    localparam int CNTW = calc_cntw(NDIG);
    localparam logic [CNTW-1:0] LAST = CNTW'(NDIG - 1);

    state_t          state;
    state_t          state_nx;
    logic [CNTW-1:0] cnt;
    logic [DW:0]     xr;        // {x, 0}: low three bits always hold the current Booth triple
    logic [CW-1:0]   cr;
    logic [AW-1:0]   sum;
    logic [AW-1:0]   carry;
    logic [AW-1:0]   acc_res;
    logic [AW-1:0]   res_nx;
    logic [AW-1:0]   pp;
    logic [AW-1:0]   maj;
    logic            pp_neg;
    digit_t          dig;
    logic            accept;
    logic [OW-1:0]   out_nx;

    assign dig    = booth_digit(xr[2:0]);
    assign accept = in_valid && in_ready;
    assign res_nx = sum + carry;
    assign maj    = (sum & carry) | (sum & pp) | (carry & pp);

    hy4_booth_pp #(
        .CW (CW),
        .AW (AW),
        .SW (CNTW)
    ) u_pp (
        .digit (dig),
        .coef  (cr),
        .shift (cnt),
        .pp    (pp),
        .neg   (pp_neg)
    );

`ifdef HY4_SAT_EN
    // Clamp when the bits above the OW sign bit are not a pure sign extension
    always_comb begin
        if ((&res_nx[AW-1:OW-1]) || !(|res_nx[AW-1:OW-1]))
            out_nx = res_nx[OW-1:0];
        else if (res_nx[AW-1])
            out_nx = {1'b1, {(OW-1){1'b0}}};
        else
            out_nx = {1'b0, {(OW-1){1'b1}}};
    end
`else
    assign out_nx = res_nx[OW-1:0];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = FIN;
            FIN:     state_nx = DONE;
            DONE:    if (out_ready) state_nx = in_valid ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:     in_ready = 1'b1;
            RUN, FIN: busy = 1'b1;
            DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: operand latch/seed, carry-save digit step, resolve and output load
    always_ff @(posedge clk) begin
        if (rst) begin
            sum     <= '0;
            carry   <= '0;
            acc_res <= '0;
            cnt     <= '0;
            xr      <= '0;
            cr      <= '0;
            out_y   <= '0;
        end else if (accept) begin
            xr    <= {in_x, 1'b0};
            cr    <= in_c;
            cnt   <= '0;
            sum   <= in_acc ? acc_res : '0;
            carry <= '0;
        end else if (state == RUN) begin
            sum   <= sum ^ carry ^ pp;
            carry <= {maj[AW-2:0], pp_neg};   // vacated LSB carries the +1 of a negated product
            xr    <= xr >> 2;
            cnt   <= cnt + 1'b1;
        end else if (state == FIN) begin
            acc_res <= res_nx;
            out_y   <= out_nx;
        end
    end

endmodule

// File: tb/tb_hy4_serial_mac.sv
module tb_hy4_serial_mac;

    localparam int DW = 14;
    localparam int CW = 8;
    localparam int GUARD = 4;
    localparam int OW = 16;
    localparam int AW = DW + CW + GUARD;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_x;
    logic [CW-1:0] in_c;
    logic          in_acc;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_y;
    logic          busy;

    int     total = 0;
    int     bad   = 0;
    longint macc  = 0;

    hy4_serial_mac #(.DW(DW), .CW(CW), .GUARD(GUARD), .OW(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_c      (in_c),
        .in_acc    (in_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrap_aw(input longint v);
        logic [AW-1:0] t;
        t = v[AW-1:0];
        return longint'($signed(t));
    endfunction

`ifdef HY4_SAT_EN
    function automatic longint expect_y(input longint a);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (OW - 1)) - 1;
        lo = -hi - 1;
        if (a > hi) return hi;
        if (a < lo) return lo;
        return a;
    endfunction
`else
    function automatic longint expect_y(input longint a);
        logic [OW-1:0] t;
        t = a[OW-1:0];
        return longint'($signed(t));
    endfunction
`endif

    function automatic longint y_now();
        return longint'($signed(out_y));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int c, input bit a);
        in_x   = x[DW-1:0];
        in_c   = c[CW-1:0];
        in_acc = a;
    endtask

    // Reference: product added to held (or zero) running sum, wrapped to AW bits
    task automatic model_accept(input int x, input int c, input bit a);
        macc = wrap_aw((a ? macc : 64'sd0) + longint'(x) * longint'(c));
    endtask

    task automatic single_op(input string tag, input int x, input int c, input bit a,
                             input longint y_exp);
        int lat;
        int bcnt;
        drive(x, c, a);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, ".in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        model_accept(x, c, a);
        lat  = 0;
        bcnt = 0;
        while (!out_valid && lat < 40) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
        chk({tag, ".latency"}, lat, 8);
        chk({tag, ".busy_cycles"}, bcnt, 8);
        chk({tag, ".y"}, y_now(), y_exp);
        step();
    endtask

    initial begin
        int     lat;
        int     gap;
        int     acc_cnt;
        int     cyc;
        int     rx;
        int     rc;
        bit     ra;
        longint q[$];

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive(0, 0, 0);
        repeat (3) step();
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_y", y_now(), 0);
        chk("rst.busy", busy, 0);
        chk("rst.in_ready", in_ready, 1);
        rst = 1'b0;

        // Accumulate straight after reset lands on zero
        single_op("t0", 3, -7, 1'b1, -21);
        single_op("t1", 3, 5, 1'b0, 15);
        single_op("t2", -8192, -128, 1'b0, expect_y(1048576));
        single_op("t3a", 100, 10, 1'b0, 1000);
        single_op("t3b", -7, 3, 1'b1, 979);
        single_op("t3c", -50, -2, 1'b0, 100);

        // Backpressure: result held, next operand waits, then same-edge acceptance
        drive(25, -4, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        model_accept(25, -4, 1'b0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("t4.latency", lat, 8);
        drive(11, 11, 1'b1);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4.hold_in_ready", in_ready, 0);
            step();
            chk("t4.hold_valid", out_valid, 1);
            chk("t4.hold_y", y_now(), -100);
        end
        out_ready = 1'b1;
        #1;
        chk("t4.in_ready", in_ready, 1);
        step();
        model_accept(11, 11, 1'b1);
        // Operands offered while busy must be ignored
        drive(9, 9, 1'b0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("t4.latency2", lat, 8);
        chk("t4.y2", y_now(), 21);
        // Back-to-back: next result rises NDIG+2 cycles after this one
        step();
        model_accept(9, 9, 1'b0);
        in_valid = 1'b0;
        gap = 1;
        while (!out_valid && gap < 40) begin
            step();
            gap++;
        end
        chk("t4.gap", gap, 9);
        chk("t4.y3", y_now(), 81);
        step();

        // Reset during the third RUN cycle discards the op and the accumulator
        drive(5, 5, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        macc = 0;
        chk("t5.out_valid", out_valid, 0);
        chk("t5.in_ready", in_ready, 1);
        chk("t5.busy", busy, 0);
        single_op("t5", 2, 2, 1'b1, 4);

        // Randomized traffic against the running-sum reference
        acc_cnt = 0;
        cyc = 0;
        in_valid = 1'b0;
        while ((acc_cnt < 1000 || q.size() > 0) && cyc < 40000) begin
            if (acc_cnt < 1000) begin
                rx = int'($urandom_range(0, 16383)) - 8192;
                rc = int'($urandom_range(0, 255)) - 128;
                ra = 1'($urandom_range(0, 1));
                in_valid = ($urandom_range(0, 3) != 0);
                drive(rx, rc, ra);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid) begin
                if (q.size() == 0) chk("r.spurious_valid", 1, 0);
                else chk("r.y", y_now(), q[0]);
            end
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                model_accept(rx, rc, ra);
                q.push_back(expect_y(macc));
                acc_cnt++;
            end
            step();
            cyc++;
        end
        chk("r.accepted", acc_cnt, 1000);
        chk("r.drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
